// File: rtl/uart_receiver.sv
// uart_receiver
//   Serial-to-parallel UART receive stage. The RX line is synchronised, then
//   oversampled: a low level in IDLE is treated as a start edge, confirmed at
//   mid start bit, and 5..9 data bits (LSB first), an optional even parity bit
//   and one or two stop bits are sampled at mid bit. The received word is
//   presented with a one-clk rx_valid pulse.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   sample_tick       one-clk pulse at OVERSAMPLE x baud
//   rx_enable         0 aborts any frame and holds IDLE
//   data_bits_cfg     data bit count 5..9 (other values: receiver stays idle)
//   parity_en         an even parity bit follows the data
//   stop_bits_cfg     2'b10 = two stop bits, anything else = one
//   RX                asynchronous serial input, idles high
//   rx_data           received word, zero-extended to 9 bits
//   rx_valid          one-clk pulse when rx_data and error flags update
//   parity_error      parity mismatch on the last frame
//   framing_error     a stop bit was sampled low on the last frame
//   busy              high whenever the receiver is not IDLE
`timescale 1ns/1ps

module uart_receiver #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_tick,
    input  logic       rx_enable,
    input  logic [3:0] data_bits_cfg,
    input  logic       parity_en,
    input  logic [1:0] stop_bits_cfg,
    input  logic       RX,
    output logic [8:0] rx_data,
    output logic       rx_valid,
    output logic       parity_error,
    output logic       framing_error,
    output logic       busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] MID_TICK = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] END_TICK = TW'(OVERSAMPLE - 1);

    typedef enum logic [4:0] {
        S_IDLE   = 5'b00001,
        S_START  = 5'b00010,
        S_DATA   = 5'b00100,
        S_PARITY = 5'b01000,
        S_STOP   = 5'b10000
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [TW-1:0]          tick_q;
    logic [3:0]             bit_cnt_q;
    logic                   stop_cnt_q;
    logic [3:0]             nbits_q;
    logic                   par_en_q;
    logic                   two_stop_q;
    logic [8:0]             shift_q;
    logic [8:0]             shift_d;
    logic                   perr_q;
    logic                   ferr_q;
    logic                   armed_q;
    logic [8:0]             rx_data_q;
    logic                   rx_valid_q;
    logic                   perr_out_q;
    logic                   ferr_out_q;

    logic rx_s;
    logic cfg_ok;

    assign rx_s   = sync_q[SYNC_STAGES-1];
    assign cfg_ok = (data_bits_cfg >= 4'd5) && (data_bits_cfg <= 4'd9);

    // Shift register with the current rx_s written into the slot for this bit.
    always_comb begin
        shift_d            = shift_q;
        shift_d[bit_cnt_q] = rx_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], RX};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tick_q     <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            nbits_q    <= '0;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            armed_q    <= 1'b1;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (!rx_enable) begin
                state_q <= S_IDLE;
            end else if (sample_tick) begin
                case (state_q)
                    S_IDLE: begin
                        // armed_q blocks a restart while the line is still low
                        // after a frame that ended on a low stop sample (break).
                        if (rx_s) begin
                            armed_q <= 1'b1;
                        end else if (armed_q && cfg_ok) begin
                            nbits_q    <= data_bits_cfg;
                            par_en_q   <= parity_en;
                            two_stop_q <= (stop_bits_cfg == 2'b10);
                            tick_q     <= '0;
                            state_q    <= S_START;
                        end
                    end
                    S_START: begin
                        if (tick_q == MID_TICK) begin
                            tick_q <= '0;
                            if (!rx_s) begin
                                bit_cnt_q <= '0;
                                shift_q   <= '0;
                                perr_q    <= 1'b0;
                                ferr_q    <= 1'b0;
                                state_q   <= S_DATA;
                            end else begin
                                state_q <= S_IDLE;
                            end
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (tick_q == END_TICK) begin
                            tick_q    <= '0;
                            shift_q   <= shift_d;
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            if (bit_cnt_q == nbits_q - 4'd1) begin
                                stop_cnt_q <= 1'b0;
                                state_q    <= par_en_q ? S_PARITY : S_STOP;
                            end
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                    S_PARITY: begin
                        if (tick_q == END_TICK) begin
                            tick_q  <= '0;
                            // unused shift bits are zero, so ^shift_q is the data parity
                            perr_q  <= rx_s ^ (^shift_q);
                            state_q <= S_STOP;
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (tick_q == END_TICK) begin
                            tick_q <= '0;
                            if (stop_cnt_q == two_stop_q) begin
                                rx_data_q  <= shift_q;
                                perr_out_q <= perr_q;
                                ferr_out_q <= ferr_q | ~rx_s;
                                rx_valid_q <= 1'b1;
                                armed_q    <= rx_s;
                                state_q    <= S_IDLE;
                            end else begin
                                ferr_q     <= ferr_q | ~rx_s;
                                stop_cnt_q <= 1'b1;
                            end
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign parity_error  = perr_out_q;
    assign framing_error = ferr_out_q;
    assign busy          = (state_q != S_IDLE);

endmodule
